ysyx_210978_mdu_issue: RTL and testbench

Requester-side controller for the multiply/divide unit in the execute stage. It accepts one M-extension operation per valid/ready handshake from the EXU and formats the operands, including the RV64 32-bit word variants. It then drives the MDU's one-hot op select and operands, waits for MDU `ready`, captures the result and holds it for the downstream stage. It also owns flush propagation to the MDU, so the MDU itself may be combinational (ready tied high) or multi-cycle.

---
 rtl/ysyx_210978_mdu_pkg.sv | 32 +++
 rtl/ysyx_210978_mdu_word_fmt.sv | 43 ++++
 rtl/ysyx_210978_mdu_issue.sv | 136 +++++++++++++
 tb/tb_ysyx_210978_mdu_issue.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_210978_mdu_pkg.sv
// Shared types for the MDU issue controller: op codes, FSM states and the
// 32-to-64 bit extension helpers used for the RV64 W-variants.
package ysyx_210978_mdu_pkg;

   localparam int XLEN = 64;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHU  = 3'd2,
      OP_MULHSU = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } mdu_state_e;

   function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
      return {{(XLEN-32){v[31]}}, v[31:0]};
   endfunction

   function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
      return {{(XLEN-32){1'b0}}, v[31:0]};
   endfunction

endpackage

// File: rtl/ysyx_210978_mdu_word_fmt.sv
// Combinational W-variant formatter: operand extension on the way into the
// MDU and result sign-extension on the way out. Used under YSYX_210978_MDU_WORD_EN.
module ysyx_210978_mdu_word_fmt
   import ysyx_210978_mdu_pkg::*;
(
   input  mdu_op_e          i_op,
   input  logic             i_word,
   input  logic [XLEN-1:0]  i_src1,
   input  logic [XLEN-1:0]  i_src2,
   output logic [XLEN-1:0]  o_src1,
   output logic [XLEN-1:0]  o_src2,
   output logic             o_word_eff,
   input  logic             i_res_word,
   input  logic [XLEN-1:0]  i_result,
   output logic [XLEN-1:0]  o_result
);

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      o_src1     = i_src1;
      o_src2     = i_src2;
      o_word_eff = 1'b0;
      if (i_word) begin
         unique case (i_op)
            OP_MUL, OP_DIV, OP_REM: begin
               o_src1     = sext32(i_src1);
               o_src2     = sext32(i_src2);
               o_word_eff = 1'b1;
            end
            OP_DIVU, OP_REMU: begin
               o_src1     = zext32(i_src1);
               o_src2     = zext32(i_src2);
               o_word_eff = 1'b1;
            end
            // The high-half multiplies have no W form; they stay 64-bit.
            default: ;
         endcase
      end
   end

   assign o_result = i_res_word ? sext32(i_result) : i_result;

endmodule

// File: rtl/ysyx_210978_mdu_issue.sv
// Requester-side MDU controller: accepts one M-extension op, drives the MDU
// until it is ready, then holds the result. W-variant formatting under YSYX_210978_MDU_WORD_EN.
module ysyx_210978_mdu_issue
   import ysyx_210978_mdu_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  mdu_op_e          in_op,
   input  logic             in_word,
   input  logic [XLEN-1:0]  in_src1,
   input  logic [XLEN-1:0]  in_src2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic             mdu_mul,
   output logic             mdu_mulh,
   output logic             mdu_mulhu,
   output logic             mdu_mulhsu,
   output logic             mdu_div,
   output logic             mdu_divu,
   output logic             mdu_rem,
   output logic             mdu_remu,
   output logic [XLEN-1:0]  mdu_src1,
   output logic [XLEN-1:0]  mdu_src2,
   output logic             mdu_flush,
   input  logic [XLEN-1:0]  mdu_result,
   input  logic             mdu_ready
);

   mdu_state_e       r_state;
   mdu_op_e          r_op;
   logic [XLEN-1:0]  r_src1;
   logic [XLEN-1:0]  r_src2;
   logic [XLEN-1:0]  r_result;

   logic [XLEN-1:0]  w_fmt1;
   logic [XLEN-1:0]  w_fmt2;
   logic [XLEN-1:0]  w_result;
   logic [7:0]       w_sel;

`ifdef YSYX_210978_MDU_WORD_EN
   logic r_word_eff;
   logic w_word_eff;

   ysyx_210978_mdu_word_fmt u_word_fmt (
      .i_op       (in_op),
      .i_word     (in_word),
      .i_src1     (in_src1),
      .i_src2     (in_src2),
      .o_src1     (w_fmt1),
      .o_src2     (w_fmt2),
      .o_word_eff (w_word_eff),
      .i_res_word (r_word_eff),
      .i_result   (mdu_result),
      .o_result   (w_result)
   );

   // The word flag only matters for the result of the op currently issued.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_word_eff <= 1'b0;
      end else if (!flush && r_state == ST_IDLE && in_valid) begin
         r_word_eff <= w_word_eff;
      end
   end
`else
   logic w_unused_word;

   assign w_unused_word = in_word;
   assign w_fmt1        = in_src1;
   assign w_fmt2        = in_src2;
   assign w_result      = mdu_result;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_op     <= OP_MUL;
         r_src1   <= '0;
         r_src2   <= '0;
         r_result <= '0;
      end else if (flush) begin
         // Flush wins over accept, MDU completion and the output handshake.
         r_state  <= ST_IDLE;
         r_result <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_state <= ST_ISSUE;
                  r_op    <= in_op;
                  r_src1  <= w_fmt1;
                  r_src2  <= w_fmt2;
               end
            end
            ST_ISSUE: begin
               if (mdu_ready) begin
                  r_result <= w_result;
                  r_state  <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_sel = (r_state == ST_ISSUE) ? (8'd1 << r_op) : 8'd0;

   assign mdu_mul    = w_sel[OP_MUL];
   assign mdu_mulh   = w_sel[OP_MULH];
   assign mdu_mulhu  = w_sel[OP_MULHU];
   assign mdu_mulhsu = w_sel[OP_MULHSU];
   assign mdu_div    = w_sel[OP_DIV];
   assign mdu_divu   = w_sel[OP_DIVU];
   assign mdu_rem    = w_sel[OP_REM];
   assign mdu_remu   = w_sel[OP_REMU];

   assign mdu_src1   = r_src1;
   assign mdu_src2   = r_src2;
   assign mdu_flush  = flush;

   assign in_ready   = (r_state == ST_IDLE);
   assign out_valid  = (r_state == ST_RESP);
   assign out_result = r_result;

endmodule

// File: tb/tb_ysyx_210978_mdu_issue.sv
// Directed bench for ysyx_210978_mdu_issue with a behavioural RV64 MDU model;
// expectations follow the YSYX_210978_MDU_WORD_EN build setting.
module tb_ysyx_210978_mdu_issue;
   import ysyx_210978_mdu_pkg::*;

   logic          clock = 1'b0;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   mdu_op_e       in_op;
   logic          in_word;
   logic [63:0]   in_src1;
   logic [63:0]   in_src2;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   out_result;
   logic          mdu_mul, mdu_mulh, mdu_mulhu, mdu_mulhsu;
   logic          mdu_div, mdu_divu, mdu_rem, mdu_remu;
   logic [63:0]   mdu_src1;
   logic [63:0]   mdu_src2;
   logic          mdu_flush;
   logic [63:0]   mdu_result;
   logic          mdu_ready;

   int            n_vec  = 0;
   int            n_miss = 0;

   logic [127:0]  m_prod;
   logic [7:0]    sel;
   logic [7:0]    sel_hold;
   logic [63:0]   res_hold;

   always #5 clock = ~clock;

   ysyx_210978_mdu_issue dut (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_word    (in_word),
      .in_src1    (in_src1),
      .in_src2    (in_src2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .mdu_mul    (mdu_mul),
      .mdu_mulh   (mdu_mulh),
      .mdu_mulhu  (mdu_mulhu),
      .mdu_mulhsu (mdu_mulhsu),
      .mdu_div    (mdu_div),
      .mdu_divu   (mdu_divu),
      .mdu_rem    (mdu_rem),
      .mdu_remu   (mdu_remu),
      .mdu_src1   (mdu_src1),
      .mdu_src2   (mdu_src2),
      .mdu_flush  (mdu_flush),
      .mdu_result (mdu_result),
      .mdu_ready  (mdu_ready)
   );

   assign sel = {mdu_remu, mdu_rem, mdu_divu, mdu_div,
                 mdu_mulhsu, mdu_mulhu, mdu_mulh, mdu_mul};

   // Behavioural RV64 MDU including the architected divide-by-zero/overflow results.
   always_comb begin
      mdu_result = '0;
      m_prod     = '0;
      if (mdu_mul) begin
         mdu_result = mdu_src1 * mdu_src2;
      end else if (mdu_mulh) begin
         m_prod     = {{64{mdu_src1[63]}}, mdu_src1} * {{64{mdu_src2[63]}}, mdu_src2};
         mdu_result = m_prod[127:64];
      end else if (mdu_mulhu) begin
         m_prod     = {64'd0, mdu_src1} * {64'd0, mdu_src2};
         mdu_result = m_prod[127:64];
      end else if (mdu_mulhsu) begin
         m_prod     = {{64{mdu_src1[63]}}, mdu_src1} * {64'd0, mdu_src2};
         mdu_result = m_prod[127:64];
      end else if (mdu_div) begin
         if (mdu_src2 == 64'd0)                                       mdu_result = '1;
         else if (mdu_src1 == 64'h8000_0000_0000_0000 && mdu_src2 == '1) mdu_result = mdu_src1;
         else                                                          mdu_result = $signed(mdu_src1) / $signed(mdu_src2);
      end else if (mdu_divu) begin
         mdu_result = (mdu_src2 == 64'd0) ? '1 : mdu_src1 / mdu_src2;
      end else if (mdu_rem) begin
         if (mdu_src2 == 64'd0)                                       mdu_result = mdu_src1;
         else if (mdu_src1 == 64'h8000_0000_0000_0000 && mdu_src2 == '1) mdu_result = '0;
         else                                                          mdu_result = $signed(mdu_src1) % $signed(mdu_src2);
      end else if (mdu_remu) begin
         mdu_result = (mdu_src2 == 64'd0) ? mdu_src1 : mdu_src1 % mdu_src2;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Full transaction with out_ready asserted as soon as the result appears.
   task automatic run_op(input string tag, input mdu_op_e op, input logic word,
                         input logic [63:0] s1, input logic [63:0] s2,
                         input logic [63:0] exp_src1, input logic [63:0] exp_res);
      check({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
      in_op    = op;
      in_word  = word;
      in_src1  = s1;
      in_src2  = s2;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, ".sel"}, {56'd0, sel}, {56'd0, 8'd1 << op});
      check({tag, ".mdu_src1"}, mdu_src1, exp_src1);
      check({tag, ".valid_issue"}, {63'd0, out_valid}, 64'd0);
      tick();
      check({tag, ".out_valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, ".result"}, out_result, exp_res);
      check({tag, ".sel_resp"}, {56'd0, sel}, 64'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, ".idle"}, {63'd0, in_ready}, 64'd1);
   endtask

`ifdef YSYX_210978_MDU_WORD_EN
   localparam logic [63:0] DIVW_SRC1  = 64'hFFFF_FFFF_8000_0000;
   localparam logic [63:0] DIVW_RES   = 64'hFFFF_FFFF_8000_0000;
   localparam logic [63:0] DIVUW_SRC1 = 64'h0000_0000_FFFF_FFFE;
   localparam logic [63:0] DIVUW_RES  = 64'h0000_0000_7FFF_FFFF;
   localparam logic [63:0] MULW_RES   = 64'hFFFF_FFFF_FFFF_FFFE;
`else
   localparam logic [63:0] DIVW_SRC1  = 64'h0000_0001_8000_0000;
   localparam logic [63:0] DIVW_RES   = 64'h0000_0001_8000_0000;
   localparam logic [63:0] DIVUW_SRC1 = 64'hFFFF_FFFF_FFFF_FFFE;
   localparam logic [63:0] DIVUW_RES  = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MULW_RES   = 64'h0000_0000_FFFF_FFFE;
`endif

   initial begin
      reset     = 1'b0;
      flush     = 1'b1;
      in_valid  = 1'b0;
      in_op     = OP_MUL;
      in_word   = 1'b0;
      in_src1   = '0;
      in_src2   = '0;
      out_ready = 1'b0;
      mdu_ready = 1'b1;

      #3;
      check("rst.mdu_flush", {63'd0, mdu_flush}, 64'd1);
      flush = 1'b0;
      #1;
      check("rst.mdu_flush_lo", {63'd0, mdu_flush}, 64'd0);
      check("rst.out_valid", {63'd0, out_valid}, 64'd0);
      check("rst.out_result", out_result, 64'd0);
      check("rst.sel", {56'd0, sel}, 64'd0);
      check("rst.mdu_src1", mdu_src1, 64'd0);
      check("rst.mdu_src2", mdu_src2, 64'd0);
      #8 reset = 1'b1;
      tick();
      check("rst.in_ready", {63'd0, in_ready}, 64'd1);

      run_op("mul",   OP_MUL,   1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA);
      run_op("divw",  OP_DIV,   1'b1, 64'h0000_0001_8000_0000, 64'd1, DIVW_SRC1, DIVW_RES);
      run_op("divuw", OP_DIVU,  1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, DIVUW_SRC1, DIVUW_RES);
      run_op("mulw",  OP_MUL,   1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, MULW_RES);
      // W flag must be ignored for the high-half multiplies.
      run_op("mulhu_w", OP_MULHU, 1'b1, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000,
             64'h0000_0001_0000_0000, 64'd1);
      run_op("mulh",  OP_MULH,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFF);

      // Slow MDU: ready first seen five cycles after ISSUE entry.
      mdu_ready = 1'b0;
      in_op = OP_DIVU; in_word = 1'b0; in_src1 = 64'd100; in_src2 = 64'd7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("slow.sel", {56'd0, sel}, {56'd0, 8'd1 << OP_DIVU});
         check("slow.no_valid", {63'd0, out_valid}, 64'd0);
         tick();
      end
      mdu_ready = 1'b1;
      check("slow.sel_ready", {56'd0, sel}, {56'd0, 8'd1 << OP_DIVU});
      tick();
      check("slow.out_valid", {63'd0, out_valid}, 64'd1);
      check("slow.result", out_result, 64'd14);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("slow.hold_valid", {63'd0, out_valid}, 64'd1);
         check("slow.hold_result", out_result, 64'd14);
         check("slow.hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("slow.done", {63'd0, in_ready}, 64'd1);

      // Flush in ISSUE with mdu_ready high: result dropped.
      in_op = OP_MUL; in_src1 = 64'd9; in_src2 = 64'd9; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      flush = 1'b1;
      #1;
      check("flush.mdu_flush", {63'd0, mdu_flush}, 64'd1);
      tick();
      flush = 1'b0;
      check("flush.in_ready", {63'd0, in_ready}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         check("flush.no_valid", {63'd0, out_valid}, 64'd0);
         tick();
      end

      // in_valid coinciding with flush in IDLE is not accepted.
      flush = 1'b1; in_valid = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush.no_accept", {63'd0, in_ready}, 64'd1);
      check("flush.no_accept_sel", {56'd0, sel}, 64'd0);

      run_op("rem0", OP_REM, 1'b0, 64'd7, 64'd0, 64'd7, 64'd7);

      // Flush in RESP discards the held result.
      in_op = OP_MULHU; in_src1 = '1; in_src2 = 64'd2; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("flresp.valid", {63'd0, out_valid}, 64'd1);
      check("flresp.result", out_result, 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flresp.dropped", {63'd0, out_valid}, 64'd0);
      check("flresp.cleared", out_result, 64'd0);

      // Reset asserted during RESP.
      in_op = OP_MUL; in_src1 = 64'd6; in_src2 = 64'd7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("rstmid.valid", {63'd0, out_valid}, 64'd1);
      check("rstmid.result", out_result, 64'd42);
      #2 reset = 1'b0;
      #1;
      check("rstmid.out_valid", {63'd0, out_valid}, 64'd0);
      check("rstmid.out_result", out_result, 64'd0);
      check("rstmid.mdu_src1", mdu_src1, 64'd0);
      check("rstmid.mdu_flush", {63'd0, mdu_flush}, 64'd0);
      reset = 1'b1;
      #1;
      check("rstmid.in_ready", {63'd0, in_ready}, 64'd1);
      tick();
      check("rstmid.stale", {63'd0, out_valid}, 64'd0);
      check("rstmid.in_ready2", {63'd0, in_ready}, 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule
